// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: state encodings,
// parity-mode constants and the 3-sample majority helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    BREAK  = ST_BREAK
  } state_t;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

  function automatic logic uart_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser on the RX pin plus the mid-bit sample history and
// the majority vote used by the frame FSM.
module uart_rx_sync_vote
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  input  logic sample_en,
  output logic rx_s,
  output logic vote
);

  logic       rx_m;
  logic [1:0] smp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      smp  <= 2'b11;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (sample_en) smp <= {smp[0], rx_s};
    end
  end

  // Third sample is the live rx_s, so the vote is final on the last sample cycle.
  assign vote = uart_maj3(smp[1], smp[0], rx_s);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: majority-voted bit sampling, false-start
// rejection, parity/framing flags, break handling and a valid/ready output.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 16,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned PARITY_EN        = 0,
  parameter int unsigned PARITY_ODD       = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CW  = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned MID = CLOCKS_PER_PULSE / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic                  stop_cnt, stop_n;
  logic [DATA_WIDTH-1:0] shreg, sh_n;
  logic                  perr_q, perr_n;
  logic                  ferr_q, ferr_n;
  logic                  done, frame_ferr;
  logic                  decide, bit_end, sample_en;
  logic                  rx_s, vote;

  uart_rx_sync_vote u_sync_vote (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .sample_en (sample_en),
    .rx_s      (rx_s),
    .vote      (vote)
  );

  assign decide    = (cnt == CNT_DEC);
  assign bit_end   = (cnt == CNT_LAST);
  assign sample_en = (state == START || state == DATA || state == PARITY || state == STOP)
                     && (cnt >= CNT_S0) && (cnt <= CNT_DEC);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      shreg    <= sh_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_cnt;
    stop_n     = stop_cnt;
    sh_n       = shreg;
    perr_n     = perr_q;
    ferr_n     = ferr_q;
    done       = 1'b0;
    frame_ferr = ferr_q;

    if (state != IDLE && state != BREAK) cnt_n = bit_end ? '0 : cnt + CW'(1);

    case (state)
      IDLE: begin
        cnt_n  = '0;
        bit_n  = '0;
        stop_n = 1'b0;
        perr_n = 1'b0;
        ferr_n = 1'b0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (decide && vote) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bit_end) begin
          state_n = DATA;
        end
      end
      DATA: begin
        // Shifting in from the MSB leaves bit 0 in the LSB after DATA_WIDTH bits.
        if (decide) sh_n = {vote, shreg[DATA_WIDTH-1:1]};
        if (bit_end) begin
          bit_n = bit_cnt + BW'(1);
          if (bit_cnt == BIT_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide) perr_n = ((^shreg) ^ vote) != PAR_MODE;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (decide) begin
          if (!vote) ferr_n = 1'b1;
          // The last stop bit ends mid-bit so a back-to-back start edge is not missed.
          if (stop_cnt == STOP_LAST) begin
            done       = 1'b1;
            frame_ferr = ferr_q | ~vote;
            state_n    = (frame_ferr && shreg == '0) ? BREAK : IDLE;
            cnt_n      = '0;
          end
        end else if (bit_end) begin
          stop_n = 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output holding register with overrun detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      busy    <= (state_n != IDLE);
      if (done) begin
        if (!valid || ready) begin
          data_out   <= shreg;
          parity_err <= (PARITY_EN != 0) && perr_q;
          frame_err  <= frame_ferr;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
